// File: rtl/if_pkg.sv
// Shared widths, reset constants and types for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [DATA_W-1:0] instr_t;

  localparam pc_t    RESET_PC  = 16'h0000;
  localparam instr_t NOP_INSTR = 16'h0000;

  // Sequential successor of a word address; wraps modulo 2^ADDR_W.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter with incrementer and branch-predictor redirect mux.
module if_pc_reg
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] target_bp,
  input  logic              target_en_bp,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  assign pc_plus1 = pc_next(pc);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (target_en_bp) begin
      pc <= target_bp;
    end else begin
      pc <= pc_plus1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC drives the instruction memory; fetched word and PC+1 go to IF/ID.
// Optional IF_FLUSH_ON_REDIRECT_EN turns the redirect-cycle slot into a NOP bubble.
module instruction_fetch
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] target_bp,
  input  logic              target_en_bp,
  input  logic [DATA_W-1:0] data_from_memory,
  output logic [ADDR_W-1:0] address_to_memory,
  output logic [ADDR_W-1:0] next_program_counter_if_to_bp,
  output logic [ADDR_W-1:0] next_program_counter_if,
  output logic [DATA_W-1:0] instruction_if
);

  pc_t pc;
  pc_t pc_plus1;

  if_pc_reg u_pc_reg (
    .clk          (clk),
    .reset        (reset),
    .target_bp    (target_bp),
    .target_en_bp (target_en_bp),
    .pc           (pc),
    .pc_plus1     (pc_plus1)
  );

  assign address_to_memory             = pc;
  assign next_program_counter_if_to_bp = pc_plus1;

  // IF/ID pipeline register; the branch word itself is kept unless flushing.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_if          <= NOP_INSTR;
      next_program_counter_if <= RESET_PC;
    end else begin
      next_program_counter_if <= pc_plus1;
`ifdef IF_FLUSH_ON_REDIRECT_EN
      instruction_if          <= target_en_bp ? NOP_INSTR : data_from_memory;
`else
      instruction_if          <= data_from_memory;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed vectors queue expectations, a monitor checks them.
module tb_instruction_fetch;
  import if_pkg::*;

`ifdef IF_FLUSH_ON_REDIRECT_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef struct {
    pc_t    addr;
    pc_t    bp;
    pc_t    npc;
    instr_t instr;
    int     id;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  pc_t    target_bp = '0;
  logic   target_en_bp = 1'b0;
  instr_t data_from_memory;
  pc_t    address_to_memory;
  pc_t    next_program_counter_if_to_bp;
  pc_t    next_program_counter_if;
  instr_t instruction_if;

  instr_t mem [0:41];
  exp_t   sb_q[$];
  int     compared = 0;
  int     mismatched = 0;
  int     vec_id = 0;

  always #5 clk = ~clk;

  // Word i holds 16'hA000 | i; addresses past the array return 16'hBAD0.
  assign data_from_memory = (address_to_memory < 16'd42) ? mem[address_to_memory[5:0]] : 16'hBAD0;

  instruction_fetch dut (
    .clk                           (clk),
    .reset                         (reset),
    .target_bp                     (target_bp),
    .target_en_bp                  (target_en_bp),
    .data_from_memory              (data_from_memory),
    .address_to_memory             (address_to_memory),
    .next_program_counter_if_to_bp (next_program_counter_if_to_bp),
    .next_program_counter_if       (next_program_counter_if),
    .instruction_if                (instruction_if)
  );

  task automatic check(input string name, input int id, input logic [15:0] actual,
                       input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic issue(input logic rst, input logic en, input pc_t tgt, input pc_t e_addr,
                       input pc_t e_bp, input pc_t e_npc, input instr_t e_instr);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    target_en_bp = en;
    target_bp    = tgt;
    e.addr  = e_addr;
    e.bp    = e_bp;
    e.npc   = e_npc;
    e.instr = (FLUSH && en && !rst) ? NOP_INSTR : e_instr;
    e.id    = vec_id++;
    sb_q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("address_to_memory", e.id, address_to_memory, e.addr);
        check("next_pc_to_bp", e.id, next_program_counter_if_to_bp, e.bp);
        check("next_pc_if", e.id, next_program_counter_if, e.npc);
        check("instruction_if", e.id, instruction_if, e.instr);
      end
    end
  end

  initial begin
    int budget;
    for (int i = 0; i < 42; i++) mem[i] = 16'hA000 | 16'(i);

    // Reset held two cycles, then sequential fetch 0..4.
    issue(1, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    issue(1, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    issue(0, 0, 16'h0000, 16'h0001, 16'h0002, 16'h0001, 16'hA000);
    issue(0, 0, 16'h0000, 16'h0002, 16'h0003, 16'h0002, 16'hA001);
    issue(0, 0, 16'h0000, 16'h0003, 16'h0004, 16'h0003, 16'hA002);
    issue(0, 0, 16'h0000, 16'h0004, 16'h0005, 16'h0004, 16'hA003);
    // Mid-run reset restarts from 0.
    issue(1, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    issue(0, 0, 16'h0000, 16'h0001, 16'h0002, 16'h0001, 16'hA000);
    issue(0, 0, 16'h0000, 16'h0002, 16'h0003, 16'h0002, 16'hA001);
    issue(0, 0, 16'h0000, 16'h0003, 16'h0004, 16'h0003, 16'hA002);
    // At PC=3 redirect to 32; branch word mem[3] still latched.
    issue(0, 1, 16'h0020, 16'h0020, 16'h0021, 16'h0004, 16'hA003);
    issue(0, 0, 16'h0000, 16'h0021, 16'h0022, 16'h0021, 16'hA020);
    // At PC=33 redirect back to 2.
    issue(0, 1, 16'h0002, 16'h0002, 16'h0003, 16'h0022, 16'hA021);
    issue(0, 0, 16'h0000, 16'h0003, 16'h0004, 16'h0003, 16'hA002);
    // Redirect to PC+1 behaves as sequential fetch.
    issue(0, 1, 16'h0004, 16'h0004, 16'h0005, 16'h0004, 16'hA003);
    // Redirect to 0xFFFF, then wrap to 0.
    issue(0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0005, 16'hA004);
    issue(0, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'hBAD0);
    issue(0, 0, 16'h0000, 16'h0001, 16'h0002, 16'h0001, 16'hA000);
    // Reset wins over a simultaneous redirect to 20.
    issue(1, 1, 16'h0014, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    issue(0, 0, 16'h0000, 16'h0001, 16'h0002, 16'h0001, 16'hA000);
    // A target with enable low is ignored.
    issue(0, 0, 16'h001E, 16'h0002, 16'h0003, 16'h0002, 16'hA001);

    @(negedge clk);
    target_bp = '0;
    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
